// File: rtl/branch_ctrl_pkg.sv
// Shared definitions for the branch controller: branch-op codes,
// FSM state encoding, PC step and the branch-target helper.
package branch_ctrl_pkg;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_LT   = 2'b01;
    localparam logic [1:0] BR_EQ   = 2'b10;
    localparam logic [1:0] BR_GT   = 2'b11;

    localparam logic [15:0] PC_STEP = 16'd2;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_WAIT_OPND,
        ST_REDIRECT
    } state_t;

    // Offset is in instruction words; scale to bytes, wrap modulo 2^16.
    function automatic logic [15:0] br_target(
        input logic [15:0] base,
        input logic [7:0]  off
    );
        return base + {{7{off[7]}}, off, 1'b0};
    endfunction

endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter that sticks at 0xFFFF.
// Ports: clk, rst (async, active-high), en (count this cycle), count.
module sat_counter16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= 16'h0000;
        else if (en && (count != 16'hFFFF))
            count <= count + 16'd1;
    end

endmodule

// File: rtl/branch_ctrl.sv
// Branch resolution in ID: owns the fetch PC, waits for operands,
// redirects on taken branches and counts resolved/taken branches.
// Ports: clk, rst; ID branch info (id_branch_op, id_pc, id_offset);
// opnd_hazard, pipe_stall, jmp_true in; cmp_op, pc, flush_ifid,
// hold_ifid, br_count, taken_count out.
module branch_ctrl
    import branch_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  id_branch_op,
    input  logic [15:0] id_pc,
    input  logic [7:0]  id_offset,
    input  logic        opnd_hazard,
    input  logic        pipe_stall,
    input  logic        jmp_true,
    output logic [1:0]  cmp_op,
    output logic [15:0] pc,
    output logic        flush_ifid,
    output logic        hold_ifid,
    output logic [15:0] br_count,
    output logic [15:0] taken_count
);

    state_t      state, state_nxt;
    logic [15:0] pc_nxt;
    logic        eval;
    logic        br_inc, tk_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
            pc    <= 16'h0000;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        cmp_op     = BR_NONE;
        flush_ifid = 1'b0;
        hold_ifid  = 1'b0;
        eval       = 1'b0;
        br_inc     = 1'b0;
        tk_inc     = 1'b0;

        // Outputs read as zero while reset is held, not only after an edge.
        if (rst) begin
            state_nxt = ST_RUN;
        end else if (pipe_stall) begin
            hold_ifid = 1'b1;
        end else begin
            unique case (state)
                ST_RUN: begin
                    if (id_branch_op == BR_NONE)
                        pc_nxt = pc + PC_STEP;
                    else if (opnd_hazard) begin
                        hold_ifid = 1'b1;
                        state_nxt = ST_WAIT_OPND;
                    end else
                        eval = 1'b1;
                end
                ST_WAIT_OPND: begin
                    if (opnd_hazard)
                        hold_ifid = 1'b1;
                    else if (id_branch_op == BR_NONE) begin
                        pc_nxt    = pc + PC_STEP;
                        state_nxt = ST_RUN;
                    end else
                        eval = 1'b1;
                end
                ST_REDIRECT: begin
                    // ID holds the squashed bubble; nothing to compare.
                    pc_nxt    = pc + PC_STEP;
                    state_nxt = ST_RUN;
                end
                default: state_nxt = ST_RUN;
            endcase

            if (eval) begin
                cmp_op = id_branch_op;
                br_inc = 1'b1;
                if (jmp_true) begin
                    flush_ifid = 1'b1;
                    tk_inc     = 1'b1;
                    pc_nxt     = br_target(id_pc, id_offset);
                    state_nxt  = ST_REDIRECT;
                end else begin
                    pc_nxt    = pc + PC_STEP;
                    state_nxt = ST_RUN;
                end
            end
        end
    end

    sat_counter16 u_br_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (br_inc),
        .count (br_count)
    );

    sat_counter16 u_tk_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (tk_inc),
        .count (taken_count)
    );

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: table of per-cycle vectors with
// a scoreboard queue, plus reset-in-wait and counter saturation runs.
module tb_branch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  id_branch_op;
    logic [15:0] id_pc;
    logic [7:0]  id_offset;
    logic        opnd_hazard;
    logic        pipe_stall;
    logic        jmp_true;
    logic [1:0]  cmp_op;
    logic [15:0] pc;
    logic        flush_ifid;
    logic        hold_ifid;
    logic [15:0] br_count;
    logic [15:0] taken_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    branch_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .id_branch_op(id_branch_op),
        .id_pc       (id_pc),
        .id_offset   (id_offset),
        .opnd_hazard (opnd_hazard),
        .pipe_stall  (pipe_stall),
        .jmp_true    (jmp_true),
        .cmp_op      (cmp_op),
        .pc          (pc),
        .flush_ifid  (flush_ifid),
        .hold_ifid   (hold_ifid),
        .br_count    (br_count),
        .taken_count (taken_count)
    );

    typedef struct {
        logic [1:0]  op;
        logic [15:0] ipc;
        logic [7:0]  off;
        logic        haz;
        logic        stl;
        logic        jmp;
        logic [1:0]  e_cmp;
        logic        e_fl;
        logic        e_hd;
        logic [15:0] e_pc;
        logic [15:0] e_br;
        logic [15:0] e_tk;
    } vec_t;

    typedef struct {
        logic [1:0]  e_cmp;
        logic        e_fl;
        logic        e_hd;
        logic [15:0] e_pc;
        logic [15:0] e_br;
        logic [15:0] e_tk;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic vec_t mk(
        input logic [1:0] op, input logic [15:0] ipc, input logic [7:0] off,
        input logic haz, input logic stl, input logic jmp,
        input logic [1:0] e_cmp, input logic e_fl, input logic e_hd,
        input logic [15:0] e_pc, input logic [15:0] e_br,
        input logic [15:0] e_tk);
        vec_t v;
        v.op = op; v.ipc = ipc; v.off = off;
        v.haz = haz; v.stl = stl; v.jmp = jmp;
        v.e_cmp = e_cmp; v.e_fl = e_fl; v.e_hd = e_hd;
        v.e_pc = e_pc; v.e_br = e_br; v.e_tk = e_tk;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [15:0] ipc,
                         input logic [7:0] off, input logic haz,
                         input logic stl, input logic jmp);
        id_branch_op = op;
        id_pc        = ipc;
        id_offset    = off;
        opnd_hazard  = haz;
        pipe_stall   = stl;
        jmp_true     = jmp;
    endtask

    initial begin
        exp_t e;
        string tag;

        // op ipc off haz stl jmp | cmp fl hd pc br tk
        vecs.push_back(mk(2'b00,16'h0000,8'h00,0,0,0, 2'b00,0,0,16'h0000,0,0));
        vecs.push_back(mk(2'b00,16'h0000,8'h00,0,0,0, 2'b00,0,0,16'h0002,0,0));
        vecs.push_back(mk(2'b00,16'h0000,8'h00,0,0,0, 2'b00,0,0,16'h0004,0,0));
        vecs.push_back(mk(2'b00,16'h0000,8'h00,0,0,0, 2'b00,0,0,16'h0006,0,0));
        vecs.push_back(mk(2'b10,16'h0010,8'hFC,0,0,1, 2'b10,1,0,16'h0008,0,0));
        vecs.push_back(mk(2'b10,16'h0010,8'hFC,0,0,1, 2'b00,0,0,16'h0008,1,1));
        vecs.push_back(mk(2'b00,16'h0000,8'h00,0,0,0, 2'b00,0,0,16'h000A,1,1));
        vecs.push_back(mk(2'b01,16'h0040,8'h10,1,0,1, 2'b00,0,1,16'h000C,1,1));
        vecs.push_back(mk(2'b01,16'h0040,8'h10,1,0,1, 2'b00,0,1,16'h000C,1,1));
        vecs.push_back(mk(2'b01,16'h0040,8'h10,0,0,0, 2'b01,0,0,16'h000C,1,1));
        vecs.push_back(mk(2'b00,16'h0000,8'h00,0,0,0, 2'b00,0,0,16'h000E,2,1));
        vecs.push_back(mk(2'b11,16'h0100,8'h02,0,1,1, 2'b00,0,1,16'h0010,2,1));
        vecs.push_back(mk(2'b11,16'h0100,8'h02,0,0,1, 2'b11,1,0,16'h0010,2,1));
        vecs.push_back(mk(2'b00,16'h0000,8'h00,0,0,0, 2'b00,0,0,16'h0104,3,2));
        vecs.push_back(mk(2'b00,16'h0000,8'h00,0,0,0, 2'b00,0,0,16'h0106,3,2));
        vecs.push_back(mk(2'b00,16'h0000,8'h00,0,1,0, 2'b00,0,1,16'h0108,3,2));
        vecs.push_back(mk(2'b00,16'h0000,8'h00,0,0,0, 2'b00,0,0,16'h0108,3,2));
        vecs.push_back(mk(2'b01,16'h0002,8'h80,1,0,1, 2'b00,0,1,16'h010A,3,2));
        vecs.push_back(mk(2'b01,16'h0002,8'h80,0,0,1, 2'b01,1,0,16'h010A,3,2));
        vecs.push_back(mk(2'b00,16'h0000,8'h00,0,0,1, 2'b00,0,0,16'hFF02,4,3));
        vecs.push_back(mk(2'b10,16'hFFF0,8'h07,0,0,1, 2'b10,1,0,16'hFF04,4,3));
        vecs.push_back(mk(2'b00,16'h0000,8'h00,0,0,0, 2'b00,0,0,16'hFFFE,5,4));
        vecs.push_back(mk(2'b00,16'h0000,8'h00,0,0,0, 2'b00,0,0,16'h0000,5,4));
        vecs.push_back(mk(2'b00,16'h0000,8'h00,0,0,0, 2'b00,0,0,16'h0002,5,4));

        drive(2'b00, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", pc, 16'h0000);
        chk("rst_cmp", {14'd0, cmp_op}, 16'd0);
        chk("rst_flush", {15'd0, flush_ifid}, 16'd0);
        chk("rst_hold", {15'd0, hold_ifid}, 16'd0);
        chk("rst_br", br_count, 16'd0);
        chk("rst_tk", taken_count, 16'd0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].op, vecs[i].ipc, vecs[i].off,
                  vecs[i].haz, vecs[i].stl, vecs[i].jmp);
            e.e_cmp = vecs[i].e_cmp;
            e.e_fl  = vecs[i].e_fl;
            e.e_hd  = vecs[i].e_hd;
            e.e_pc  = vecs[i].e_pc;
            e.e_br  = vecs[i].e_br;
            e.e_tk  = vecs[i].e_tk;
            sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front();
            tag = $sformatf("v%0d", i);
            chk({tag, "_cmp"}, {14'd0, cmp_op}, {14'd0, e.e_cmp});
            chk({tag, "_flush"}, {15'd0, flush_ifid}, {15'd0, e.e_fl});
            chk({tag, "_hold"}, {15'd0, hold_ifid}, {15'd0, e.e_hd});
            chk({tag, "_pc"}, pc, e.e_pc);
            chk({tag, "_br"}, br_count, e.e_br);
            chk({tag, "_tk"}, taken_count, e.e_tk);
            @(posedge clk);
            #1;
        end
        chk("sb_empty", 16'(sb.size()), 16'd0);

        // Reset asserted mid-wait: outputs clear without a clock edge.
        drive(2'b01, 16'h0020, 8'h04, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk("w_hold", {15'd0, hold_ifid}, 16'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("wr_pc", pc, 16'h0000);
        chk("wr_hold", {15'd0, hold_ifid}, 16'd0);
        chk("wr_cmp", {14'd0, cmp_op}, 16'd0);
        chk("wr_flush", {15'd0, flush_ifid}, 16'd0);
        chk("wr_br", br_count, 16'd0);
        chk("wr_tk", taken_count, 16'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(2'b00, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("rel_pc0", pc, 16'h0000);
        @(negedge clk);
        chk("rel_pc1", pc, 16'h0002);
        chk("rel_br", br_count, 16'd0);

        // Back-to-back not-taken branches drive br_count into saturation.
        @(posedge clk);
        #1;
        drive(2'b01, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (65534) @(posedge clk);
        @(negedge clk);
        chk("sat_pre", br_count, 16'hFFFE);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("sat_hold", br_count, 16'hFFFF);
        chk("sat_tk", taken_count, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 clk  input  1  sole clock; all state updates on its rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 id_branch_op  input  2  branch op of instruction in ID: 00 none, 01 less-than, 10 equal, 11 greater-than.
REQ-004 id_pc  input  16  byte address of instruction in ID.
REQ-005 id_offset  input  8  signed branch offset of instruction in ID, in instruction words.
REQ-006 opnd_hazard  input  1  a compare operand is still being produced in EX/MEM.
REQ-007 pipe_stall  input  1  external stall from the memory or hazard unit; freezes this block.
REQ-008 jmp_true  input  1  comparator result for the current cmp_op (combinational, same cycle).
REQ-009 cmp_op  output  2  branch op driven to the comparator; 00 whenever no evaluation is allowed.
REQ-010 pc  output  16  fetch address register.
REQ-011 flush_ifid  output  1  one-cycle pulse that squashes the IF/ID instruction.
REQ-012 hold_ifid  output  1  holds the IF/ID register and inserts a bubble into ID/EX.
REQ-013 br_count, taken_count  output  16 each  saturating count of resolved branches and taken branches.

Function
REQ-014 States: RUN, WAIT_OPND, REDIRECT.
- RUN: if id_branch_op==00, pc <= pc+2.
- RUN, branch with opnd_hazard=1: go to WAIT_OPND; cmp_op=00; hold_ifid=1; pc holds.
- RUN, branch with opnd_hazard=0: this is the evaluate cycle; cmp_op=id_branch_op.
REQ-015 WAIT_OPND: cmp_op=00, hold_ifid=1, pc holds; when opnd_hazard=0, this is the evaluate cycle (same actions as RUN evaluate); no cap on wait length.
REQ-016 Evaluate, jmp_true=1:
- pc <= id_pc + (sign_extend(id_offset) << 1), modulo 2^16.
- flush_ifid=1 in this cycle; next state REDIRECT.
- br_count and taken_count each +1.
REQ-017 Evaluate, jmp_true=0: pc <= pc+2; br_count +1; next state RUN.
REQ-018 REDIRECT lasts one cycle: pc <= pc+2; cmp_op=00 because the ID slot holds a squashed bubble; then RUN.
REQ-019 jmp_true is ignored outside evaluate cycles.
REQ-020 Branch penalty: exactly 1 cycle when taken, 0 when not taken, plus 1 cycle per WAIT_OPND cycle.
REQ-021 pipe_stall=1 overrides all else:
- state, pc and counters hold;
- cmp_op=00, flush_ifid=0, hold_ifid=1.
REQ-022 PC arithmetic wraps: 0xFFFE+2 -> 0x0000; a branch target below 0 or above 0xFFFE wraps modulo 2^16.
REQ-023 Counters saturate at 0xFFFF and do not wrap.
REQ-024 flush_ifid and hold_ifid are never both 1 in the same cycle; flush takes precedence.

Reset
REQ-025 rst=1 immediately forces: state RUN, pc=0x0000, cmp_op=00, flush_ifid=0, hold_ifid=0, br_count=0, taken_count=0.
REQ-026 Reset during WAIT_OPND or REDIRECT abandons the pending branch; the first cycle after release fetches 0x0000.

Structure
REQ-027 The shared package holds:
- branch-op constants BR_NONE=00, BR_LT=01, BR_EQ=10, BR_GT=11;
- the state encoding;
- PC_STEP=2.
REQ-028 One sub-module, sat_counter16 (enable, async reset, saturating), is instantiated twice for br_count and taken_count.

Verification
REQ-029 Reset, then no branches for 4 cycles -> pc 0x0000, 0x0002, 0x0004, 0x0006; all flags 0.
REQ-030 id_pc=0x0010, id_offset=0xFC, op=10, hazard=0, jmp_true=1 -> cmp_op=10 and flush_ifid=1 that cycle; next pc=0x0008; then REDIRECT for 1 cycle; br_count=1, taken_count=1.
REQ-031 Op=01 with opnd_hazard=1 for 2 cycles, then 0 with jmp_true=0:
- 2 cycles of hold_ifid=1 with cmp_op=00;
- evaluate cycle with cmp_op=01, then pc+2;
- taken_count unchanged.
REQ-032 pipe_stall=1 during an evaluate cycle with jmp_true=1 -> no pc change, no flush; the branch resolves on the first cycle after stall drops.
REQ-033 pc=0xFFFE with no branch -> next pc 0x0000; id_pc=0x0002 with id_offset=0x80 taken -> pc=0xFF02.
REQ-034 rst asserted mid-WAIT_OPND -> outputs zero immediately; after release pc runs from 0x0000 with counters at 0.
